// File: rtl/load_exec_unit_pkg.sv
// Shared definitions for the load execution stage: FSM encoding, load op codes
// and the reserved "no producer" label, kept alongside the queue label defines.
package load_exec_unit_pkg;

  typedef enum logic [1:0] {
    LEU_IDLE  = 2'd0,
    LEU_MEM   = 2'd1,
    LEU_BCAST = 2'd2
  } leu_state_e;

  localparam logic OP_LW  = 1'b0;
  localparam logic OP_LBU = 1'b1;

  // Label 0 marks an operand with no producer and must never appear on the CDB.
  localparam int unsigned LABEL_NONE = 0;

endpackage

// File: rtl/load_exec_unit_load_align.sv
// Combinational load result formatter: passes a full word or selects one
// little-endian byte lane and zero-extends it.
module load_align
  import load_exec_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr_lo,
  input  logic              op,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    result  = rdata;
    if (op == OP_LBU) begin
      result = {{(DATA_W-8){1'b0}}, shifted[7:0]};
    end
  end

endmodule

// File: rtl/load_exec_unit.sv
// Load execution stage: accepts the load queue head, performs a variable-latency
// memory read, formats the result and broadcasts it on the CDB under its label.
module load_exec_unit
  import load_exec_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 4
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               require,
  input  logic               opIn,
  input  logic [DATA_W-1:0]  dataIn,
  input  logic [LABEL_W-1:0] labelIn,
  output logic               requireAC,
  output logic               isLastState,
  output logic               mem_req,
  output logic [DATA_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               BCreq,
  input  logic               BCgrant,
  output logic [LABEL_W-1:0] BClabelOut,
  output logic [DATA_W-1:0]  BCdataOut
);

  leu_state_e         state_q, state_d;
  logic               op_q;
  logic [DATA_W-1:0]  addr_q;
  logic [LABEL_W-1:0] label_q;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  aligned;
  logic               has_label;

  load_align #(.DATA_W(DATA_W)) u_align (
    .rdata   (mem_rdata),
    .addr_lo (addr_q[1:0]),
    .op      (op_q),
    .result  (aligned)
  );

  assign has_label  = (label_q != LABEL_W'(LABEL_NONE));
  assign mem_addr   = {addr_q[DATA_W-1:2], 2'b00};
  assign BClabelOut = label_q;
  assign BCdataOut  = data_q;

  always_ff @(posedge clk) begin
    if (RST) state_q <= LEU_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      op_q    <= OP_LW;
      addr_q  <= '0;
      label_q <= '0;
      data_q  <= '0;
    end else begin
      if (isLastState) begin
        op_q    <= opIn;
        addr_q  <= dataIn;
        label_q <= labelIn;
      end
      if (state_q == LEU_MEM && mem_ack) begin
        data_q <= aligned;
      end
    end
  end

  // A pop during reset would lose an entry the unit never latched, so RST gates it.
  always_comb begin
    state_d     = state_q;
    requireAC   = 1'b0;
    isLastState = 1'b0;
    mem_req     = 1'b0;
    BCreq       = 1'b0;
    case (state_q)
      LEU_IDLE: begin
        requireAC = 1'b1;
        if (require && !RST) begin
          isLastState = 1'b1;
          state_d     = LEU_MEM;
        end
      end
      LEU_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = LEU_BCAST;
      end
      LEU_BCAST: begin
        // Label-zero results complete silently without claiming the CDB.
        if (has_label) begin
          BCreq = 1'b1;
          if (BCgrant) state_d = LEU_IDLE;
        end else begin
          state_d = LEU_IDLE;
        end
      end
      default: state_d = LEU_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_exec_unit.sv
// Directed self-checking bench for load_exec_unit: reset, word/byte loads,
// memory and CDB stalls, reset mid-flight and back-to-back entries.
module tb_load_exec_unit;

  logic        clk = 1'b0;
  logic        RST;
  logic        require;
  logic        opIn;
  logic [31:0] dataIn;
  logic [3:0]  labelIn;
  logic        requireAC;
  logic        isLastState;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        BCreq;
  logic        BCgrant;
  logic [3:0]  BClabelOut;
  logic [31:0] BCdataOut;

  int checkCount = 0;
  int errorCount = 0;
  int cycle = 0;
  int popCycles[$];

  load_exec_unit #(.DATA_W(32), .LABEL_W(4)) dut (
    .clk        (clk),
    .RST        (RST),
    .require    (require),
    .opIn       (opIn),
    .dataIn     (dataIn),
    .labelIn    (labelIn),
    .requireAC  (requireAC),
    .isLastState(isLastState),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .BCreq      (BCreq),
    .BCgrant    (BCgrant),
    .BClabelOut (BClabelOut),
    .BCdataOut  (BCdataOut)
  );

  always #5 clk = ~clk;

  // Records the cycle of every pop so spacing and total count can be checked.
  always @(posedge clk) begin
    if (isLastState) popCycles.push_back(cycle);
    cycle = cycle + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one load end to end with the given memory and CDB stall lengths.
  task automatic applyStimulus(input string tag, input logic op, input logic [31:0] addr,
                               input logic [3:0] label, input logic [31:0] rdata,
                               input int ackDelay, input int grantDelay,
                               input logic [31:0] expData, input bit holdRequire);
    int pulses;
    pulses  = 0;
    require = 1'b1;
    opIn    = op;
    dataIn  = addr;
    labelIn = label;
    #1;
    checkOutput({tag, ".pop"}, {31'd0, isLastState}, 32'd1);
    checkOutput({tag, ".acIdle"}, {31'd0, requireAC}, 32'd1);
    tick();
    if (!holdRequire) begin
      require = 1'b0;
      opIn    = ~op;
      dataIn  = 32'hFFFF_FFFF;
      labelIn = 4'hF;
    end
    #1;
    for (int i = 0; i <= ackDelay; i++) begin
      checkOutput({tag, ".memReq"}, {31'd0, mem_req}, 32'd1);
      checkOutput({tag, ".memAddr"}, mem_addr, addr & 32'hFFFF_FFFC);
      checkOutput({tag, ".acBusy"}, {31'd0, requireAC}, 32'd0);
      checkOutput({tag, ".bcMem"}, {31'd0, BCreq}, 32'd0);
      pulses += int'(isLastState);
      if (i == ackDelay) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      tick();
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'hA5A5_5A5A;
    #1;
    for (int i = 0; i <= grantDelay; i++) begin
      checkOutput({tag, ".bcReq"}, {31'd0, BCreq}, 32'd1);
      checkOutput({tag, ".bcLabel"}, {28'd0, BClabelOut}, {28'd0, label});
      checkOutput({tag, ".bcData"}, BCdataOut, expData);
      checkOutput({tag, ".memIdle"}, {31'd0, mem_req}, 32'd0);
      pulses += int'(isLastState);
      if (i == grantDelay) BCgrant = 1'b1;
      tick();
    end
    BCgrant = 1'b0;
    require = 1'b0;
    #1;
    checkOutput({tag, ".acAfter"}, {31'd0, requireAC}, 32'd1);
    checkOutput({tag, ".bcDone"}, {31'd0, BCreq}, 32'd0);
    checkOutput({tag, ".extraPops"}, pulses, 32'd0);
  endtask

  initial begin
    RST       = 1'b1;
    require   = 1'b0;
    opIn      = 1'b0;
    dataIn    = '0;
    labelIn   = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    BCgrant   = 1'b0;
    tick();
    tick();
    checkOutput("rst.requireAC", {31'd0, requireAC}, 32'd1);
    checkOutput("rst.memReq", {31'd0, mem_req}, 32'd0);
    checkOutput("rst.bcReq", {31'd0, BCreq}, 32'd0);
    checkOutput("rst.pop", {31'd0, isLastState}, 32'd0);
    checkOutput("rst.memAddr", mem_addr, 32'd0);
    checkOutput("rst.bcLabel", {28'd0, BClabelOut}, 32'd0);
    checkOutput("rst.bcData", BCdataOut, 32'd0);
    RST = 1'b0;
    tick();

    applyStimulus("lw", 1'b0, 32'h0000_0104, 4'h5, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 1'b0);
    applyStimulus("lbu3", 1'b1, 32'h0000_0203, 4'h6, 32'h1122_3344, 0, 0, 32'h0000_0011, 1'b0);
    applyStimulus("lbu1", 1'b1, 32'h0000_0201, 4'h7, 32'h1122_3344, 1, 0, 32'h0000_0033, 1'b0);
    applyStimulus("stall", 1'b1, 32'h0000_0402, 4'h9, 32'hCAFE_F00D, 5, 4, 32'h0000_00FE, 1'b0);
    applyStimulus("hold", 1'b0, 32'h0000_0808, 4'hA, 32'h0123_4567, 2, 1, 32'h0123_4567, 1'b1);

    require = 1'b1;
    opIn    = 1'b0;
    dataIn  = 32'h0000_0300;
    labelIn = 4'h7;
    tick();
    require = 1'b0;
    #1;
    checkOutput("rstMem.memReq", {31'd0, mem_req}, 32'd1);
    RST       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    RST     = 1'b0;
    mem_ack = 1'b0;
    #1;
    checkOutput("rstMem.memIdle", {31'd0, mem_req}, 32'd0);
    checkOutput("rstMem.noBc", {31'd0, BCreq}, 32'd0);
    checkOutput("rstMem.ac", {31'd0, requireAC}, 32'd1);
    checkOutput("rstMem.addrClr", mem_addr, 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    checkOutput("stray.noBc", {31'd0, BCreq}, 32'd0);
    checkOutput("stray.noMem", {31'd0, mem_req}, 32'd0);
    checkOutput("stray.data", BCdataOut, 32'd0);
    tick();
    checkOutput("stray.noBcLater", {31'd0, BCreq}, 32'd0);

    applyStimulus("b2b1", 1'b0, 32'h0000_1000, 4'h1, 32'h0000_AAAA, 0, 0, 32'h0000_AAAA, 1'b0);
    applyStimulus("b2b2", 1'b1, 32'h0000_1001, 4'h2, 32'h0000_BB00, 0, 0, 32'h0000_00BB, 1'b0);
    tick();

    checkOutput("popTotal", popCycles.size(), 32'd8);
    if (popCycles.size() >= 2) begin
      checkOutput("b2b.gap", {31'd0, (popCycles[$] - popCycles[$-1]) >= 3}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
